// File: rtl/bsg_popcount_seq_pkg.sv
// bsg_popcount_seq_pkg: shared state encoding and width helpers for the popcount sequencer
package bsg_popcount_seq_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction
  function automatic int idx_width(input int els);
    return els > 1 ? $clog2(els) : 1;
  endfunction
endpackage

// File: rtl/bsg_popcount.sv
// bsg_popcount: combinational count of set bits in a width_p-bit vector
module bsg_popcount
  import bsg_popcount_seq_pkg::*;
#(
  parameter int width_p = 32,
  localparam int w_lp = cnt_width(width_p)
) (
  input  logic [width_p-1:0] i,
  output logic [w_lp-1:0]    o
);
  always_comb begin
    o = '0;
    for (int k = 0; k < width_p; k++) o = o + w_lp'(i[k]);
  end
endmodule

// File: rtl/bsg_popcount_seq.sv
// bsg_popcount_seq: multi-cycle popcount, one slice per cycle, valid/ready in and valid/yumi out.
// Optional BSG_POPCOUNT_SEQ_SKIP_ZERO_EN finishes early once the remaining slices are all zero.
module bsg_popcount_seq
  import bsg_popcount_seq_pkg::*;
#(
  parameter int width_p = 256,
  parameter int slice_width_p = 32,
  localparam int els_lp = width_p / slice_width_p,
  localparam int cnt_width_lp = cnt_width(width_p),
  localparam int slice_cnt_width_lp = cnt_width(slice_width_p),
  localparam int idx_width_lp = idx_width(els_lp)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    v_i,
  input  logic [width_p-1:0]      data_i,
  output logic                    ready_o,
  output logic                    v_o,
  output logic [cnt_width_lp-1:0] count_o,
  input  logic                    yumi_i
);
  state_e state_r, state_n;
  logic [cnt_width_lp-1:0] acc_r;
  logic [idx_width_lp-1:0] idx_r;
  logic [width_p-1:0] shift_r;
  logic [slice_cnt_width_lp-1:0] slice_cnt;
  logic busy_done;

  bsg_popcount #(.width_p(slice_width_p)) pc (
    .i(shift_r[slice_width_p-1:0]),
    .o(slice_cnt)
  );

`ifdef BSG_POPCOUNT_SEQ_SKIP_ZERO_EN
  // Bits above the current slice are all zero, so nothing remains to count.
  assign busy_done = idx_r == idx_width_lp'(els_lp - 1) || (shift_r >> slice_width_p) == '0;
`else
  assign busy_done = idx_r == idx_width_lp'(els_lp - 1);
`endif

  always_comb begin
    state_n = (state_r == IDLE && v_i) ? BUSY
            : (state_r == BUSY && busy_done) ? DONE
            : (state_r == DONE && yumi_i) ? IDLE
            : state_r;
  end

  assign ready_o = state_r == IDLE;
  assign v_o = state_r == DONE;
  assign count_o = acc_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      acc_r <= '0;
      idx_r <= '0;
      shift_r <= '0;
    end else begin
      state_r <= state_n;
      if (state_r == IDLE && v_i) begin
        shift_r <= data_i;
        acc_r <= '0;
        idx_r <= '0;
      end else if (state_r == BUSY) begin
        acc_r <= acc_r + cnt_width_lp'(slice_cnt);
        shift_r <= shift_r >> slice_width_p;
        idx_r <= idx_r + idx_width_lp'(1);
      end
    end
  end

  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
endmodule
